// File: rtl/psr_bank_pkg.sv
// psr_bank_pkg: shared constants for the PSR bank.
// Holds the default register layout (field LSB positions), the default
// parameter values and the bit positions of the ld field-write mask.
package psr_bank_pkg;

    // Default geometry
    localparam int unsigned PSR_WIDTH     = 32;
    localparam int unsigned PSR_CTRL_W    = 6;
    localparam int unsigned PSR_MASK_W    = 4;
    localparam int unsigned PSR_NUM_BANKS = 4;

    // Field LSB positions for the default geometry
    localparam int unsigned CTRL_LSB  = 0;
    localparam int unsigned MASK_LSB  = CTRL_LSB + PSR_CTRL_W;
    localparam int unsigned UPPER_LSB = MASK_LSB + PSR_MASK_W;
    localparam int unsigned FLAG_LSB  = PSR_WIDTH - 4;

    // ld bit encodings
    localparam int unsigned LD_MASK_BIT  = 0;
    localparam int unsigned LD_CTRL_BIT  = 1;
    localparam int unsigned LD_UPPER_BIT = 2;

endpackage

// File: rtl/psr_spsr_file.sv
// psr_spsr_file: saved-status register file for banks 1..NUM_BANKS-1.
// Bank 0 has no storage; a read of address 0 returns zero and a write to
// address 0 is ignored.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset, clears every entry
//   i_we     - write enable
//   i_waddr  - write bank index
//   i_wdata  - write data
//   i_raddr  - read bank index
//   o_rdata  - read data (zero for bank 0)
module psr_spsr_file
    import psr_bank_pkg::*;
#(
    parameter int unsigned WIDTH     = PSR_WIDTH,
    parameter int unsigned NUM_BANKS = PSR_NUM_BANKS,
    parameter int unsigned BW        = $clog2(NUM_BANKS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [BW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [BW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [NUM_BANKS-1:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NUM_BANKS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_raddr != '0) begin
            o_rdata = r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/psr_bank.sv
// psr_bank: banked program status register.
// Holds the current status register (CPSR) and one saved register per
// non-user bank. Exception entry saves CPSR into the target bank and
// switches mode; exception return restores CPSR from the current bank.
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous active-high reset
//   ld        - field write mask: bit0 mask, bit1 control, bit2 upper
//   Din       - write data for ld and spsr_ld
//   flag_we   - condition-flag update strobe
//   flags_in  - new flags for the top four bits
//   exc_req   - exception entry strobe
//   exc_bank  - target bank for exception entry
//   exc_ret   - exception return strobe
//   spsr_ld   - write Din to the saved register of the current bank
//   Dout      - current status register
//   spsr_out  - saved register of the current bank (zero in bank 0)
//   err       - sticky error flag, cleared only by reset
// WIDTH must be at least 16.
module psr_bank
    import psr_bank_pkg::*;
#(
    parameter int unsigned WIDTH     = PSR_WIDTH,
    parameter int unsigned CTRL_W    = PSR_CTRL_W,
    parameter int unsigned MASK_W    = PSR_MASK_W,
    parameter int unsigned NUM_BANKS = PSR_NUM_BANKS,
    parameter int unsigned BW        = $clog2(NUM_BANKS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       ld,
    input  logic [WIDTH-1:0] Din,
    input  logic             flag_we,
    input  logic [3:0]       flags_in,
    input  logic             exc_req,
    input  logic [BW-1:0]    exc_bank,
    input  logic             exc_ret,
    input  logic             spsr_ld,
    output logic [WIDTH-1:0] Dout,
    output logic [WIDTH-1:0] spsr_out,
    output logic             err
);

    localparam int unsigned MaskLsb  = CTRL_LSB + CTRL_W;
    localparam int unsigned UpperLsb = MaskLsb + MASK_W;

    logic [WIDTH-1:0] r_cpsr;
    logic             r_err;

    logic [WIDTH-1:0] w_cpsr_d;
    logic             w_err_d;
    logic [BW-1:0]    w_cb;
    logic [WIDTH-1:0] w_ctrl_m;
    logic [WIDTH-1:0] w_mask_m;
    logic [WIDTH-1:0] w_upper_m;
    logic [WIDTH-1:0] w_ld_m;
    logic             w_spsr_we;
    logic [BW-1:0]    w_spsr_waddr;
    logic [WIDTH-1:0] w_spsr_wdata;
    logic [WIDTH-1:0] w_spsr_rdata;

    assign w_cb = r_cpsr[BW-1:0];

    // Per-bit field membership masks
    always_comb begin
        w_ctrl_m  = '0;
        w_mask_m  = '0;
        w_upper_m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ctrl_m[i]  = (i < MaskLsb);
            w_mask_m[i]  = (i >= MaskLsb) && (i < UpperLsb);
            w_upper_m[i] = (i >= UpperLsb);
        end
    end

    // Union of fields selected by ld
    always_comb begin
        w_ld_m = '0;
        if (ld[LD_MASK_BIT])  w_ld_m = w_ld_m | w_mask_m;
        if (ld[LD_CTRL_BIT])  w_ld_m = w_ld_m | w_ctrl_m;
        if (ld[LD_UPPER_BIT]) w_ld_m = w_ld_m | w_upper_m;
    end

    always_comb begin
        w_cpsr_d     = r_cpsr;
        w_err_d      = r_err;
        w_spsr_we    = 1'b0;
        w_spsr_waddr = w_cb;
        w_spsr_wdata = Din;
        if (exc_req) begin
            if (exc_bank != '0) begin
                w_spsr_we           = 1'b1;
                w_spsr_waddr        = exc_bank;
                w_spsr_wdata        = r_cpsr;
                w_cpsr_d            = r_cpsr | w_mask_m;
                w_cpsr_d[BW-1:0]    = exc_bank;
            end else begin
                w_err_d = 1'b1;
            end
        end else if (exc_ret) begin
            if (w_cb != '0) begin
                w_cpsr_d = w_spsr_rdata;
            end else begin
                w_err_d = 1'b1;
            end
        end else begin
            // spsr_ld targets the bank in force before this cycle's ld
            if (spsr_ld) begin
                if (w_cb != '0) begin
                    w_spsr_we = 1'b1;
                end else begin
                    w_err_d = 1'b1;
                end
            end
            w_cpsr_d = (r_cpsr & ~w_ld_m) | (Din & w_ld_m);
            // Flags are applied last so they override an overlapping ld
            if (flag_we) begin
                w_cpsr_d[WIDTH-1 -: 4] = flags_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpsr <= '0;
            r_err  <= 1'b0;
        end else begin
            r_cpsr <= w_cpsr_d;
            r_err  <= w_err_d;
        end
    end

    psr_spsr_file #(
        .WIDTH     (WIDTH),
        .NUM_BANKS (NUM_BANKS),
        .BW        (BW)
    ) u_spsr_file (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_spsr_we),
        .i_waddr (w_spsr_waddr),
        .i_wdata (w_spsr_wdata),
        .i_raddr (w_cb),
        .o_rdata (w_spsr_rdata)
    );

    assign Dout     = r_cpsr;
    assign spsr_out = w_spsr_rdata;
    assign err      = r_err;

endmodule

// File: tb/tb_psr_bank.sv
// tb_psr_bank: directed vector table followed by randomized traffic checked
// against a field-level reference model of the status register bank.
module tb_psr_bank;
    import psr_bank_pkg::*;

    localparam int unsigned NB = PSR_NUM_BANKS;

    logic        clk;
    logic        reset;
    logic [2:0]  ld;
    logic [31:0] Din;
    logic        flag_we;
    logic [3:0]  flags_in;
    logic        exc_req;
    logic [1:0]  exc_bank;
    logic        exc_ret;
    logic        spsr_ld;
    logic [31:0] Dout;
    logic [31:0] spsr_out;
    logic        err;

    int total;
    int bad;

    psr_bank dut (
        .clk      (clk),
        .reset    (reset),
        .ld       (ld),
        .Din      (Din),
        .flag_we  (flag_we),
        .flags_in (flags_in),
        .exc_req  (exc_req),
        .exc_bank (exc_bank),
        .exc_ret  (exc_ret),
        .spsr_ld  (spsr_ld),
        .Dout     (Dout),
        .spsr_out (spsr_out),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [2:0]  ld;
        logic [31:0] din;
        bit          fwe;
        logic [3:0]  fl;
        bit          er;
        logic [1:0]  eb;
        bit          ret;
        bit          sld;
        logic [31:0] exp_dout;
        logic [31:0] exp_spsr;
        bit          exp_err;
    } vec_t;

    function automatic vec_t mk(bit rst, logic [2:0] l, logic [31:0] d, bit fwe, logic [3:0] fl,
                                bit er, logic [1:0] eb, bit ret, bit sld,
                                logic [31:0] ed, logic [31:0] es, bit ee);
        vec_t v;
        v.rst = rst; v.ld = l; v.din = d; v.fwe = fwe; v.fl = fl;
        v.er = er; v.eb = eb; v.ret = ret; v.sld = sld;
        v.exp_dout = ed; v.exp_spsr = es; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic drive(input bit rst, input logic [2:0] l, input logic [31:0] d, input bit fwe,
                         input logic [3:0] fl, input bit er, input logic [1:0] eb,
                         input bit ret, input bit sld);
        @(negedge clk);
        reset = rst; ld = l; Din = d; flag_we = fwe; flags_in = fl;
        exc_req = er; exc_bank = eb; exc_ret = ret; spsr_ld = sld;
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic [31:0] m_cpsr;
    logic [31:0] m_spsr [NB];
    bit          m_err;

    function automatic logic [31:0] field(int unsigned lo, int unsigned hi);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) if (i >= lo && i < hi) m[i] = 1'b1;
        return m;
    endfunction

    task automatic model_step(input bit rst, input logic [2:0] l, input logic [31:0] d,
                              input bit fwe, input logic [3:0] fl, input bit er,
                              input logic [1:0] eb, input bit ret, input bit sld);
        int unsigned cb;
        logic [31:0] nxt;
        cb = m_cpsr % NB;
        if (rst) begin
            m_cpsr = '0;
            for (int i = 0; i < NB; i++) m_spsr[i] = '0;
            m_err = 0;
        end else if (er) begin
            if (eb != 0) begin
                m_spsr[eb] = m_cpsr;
                m_cpsr = ((m_cpsr | field(MASK_LSB, UPPER_LSB)) & ~(NB - 1)) | 32'(eb);
            end else begin
                m_err = 1;
            end
        end else if (ret) begin
            if (cb != 0) m_cpsr = m_spsr[cb];
            else m_err = 1;
        end else begin
            if (sld) begin
                if (cb != 0) m_spsr[cb] = d;
                else m_err = 1;
            end
            nxt = m_cpsr;
            if (l[LD_MASK_BIT])
                nxt = (nxt & ~field(MASK_LSB, UPPER_LSB)) | (d & field(MASK_LSB, UPPER_LSB));
            if (l[LD_CTRL_BIT])
                nxt = (nxt & ~field(CTRL_LSB, MASK_LSB)) | (d & field(CTRL_LSB, MASK_LSB));
            if (l[LD_UPPER_BIT])
                nxt = (nxt & ~field(UPPER_LSB, 32)) | (d & field(UPPER_LSB, 32));
            if (fwe)
                nxt = (nxt & ~field(FLAG_LSB, 32)) | (32'(fl) << FLAG_LSB);
            m_cpsr = nxt;
        end
    endtask

    vec_t vecs [25];

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1; ld = '0; Din = '0; flag_we = 1'b0; flags_in = '0;
        exc_req = 1'b0; exc_bank = '0; exc_ret = 1'b0; spsr_ld = 1'b0;

        //            rst ld    din           fwe fl    er eb ret sld  dout          spsr          err
        vecs[0]  = mk(1, 3'b000, 32'h0,        0, 4'h0, 0, 0, 0, 0, 32'h0000_0000, 32'h0,        0);
        vecs[1]  = mk(0, 3'b111, 32'hA5A5_A5A5, 0, 4'h0, 0, 0, 0, 0, 32'hA5A5_A5A5, 32'h0,        0);
        vecs[2]  = mk(1, 3'b000, 32'h0,        0, 4'h0, 0, 0, 0, 0, 32'h0000_0000, 32'h0,        0);
        vecs[3]  = mk(0, 3'b101, 32'hFFFF_FFFF, 0, 4'h0, 0, 0, 0, 0, 32'hFFFF_FFC0, 32'h0,        0);
        vecs[4]  = mk(1, 3'b000, 32'h0,        0, 4'h0, 0, 0, 0, 0, 32'h0000_0000, 32'h0,        0);
        vecs[5]  = mk(0, 3'b101, 32'hFFFF_FFFF, 1, 4'h5, 0, 0, 0, 0, 32'h5FFF_FFC0, 32'h0,        0);
        vecs[6]  = mk(1, 3'b000, 32'h0,        0, 4'h0, 0, 0, 0, 0, 32'h0000_0000, 32'h0,        0);
        vecs[7]  = mk(0, 3'b100, 32'h8000_0000, 0, 4'h0, 0, 0, 0, 0, 32'h8000_0000, 32'h0,        0);
        vecs[8]  = mk(0, 3'b000, 32'h0,        0, 4'h0, 1, 2, 0, 0, 32'h8000_03C2, 32'h8000_0000, 0);
        vecs[9]  = mk(0, 3'b000, 32'h0,        0, 4'h0, 1, 3, 0, 0, 32'h8000_03C3, 32'h8000_03C2, 0);
        vecs[10] = mk(0, 3'b000, 32'h0,        0, 4'h0, 0, 0, 1, 0, 32'h8000_03C2, 32'h8000_0000, 0);
        vecs[11] = mk(0, 3'b000, 32'h0,        0, 4'h0, 0, 0, 1, 0, 32'h8000_0000, 32'h0,        0);
        vecs[12] = mk(0, 3'b000, 32'h0,        0, 4'h0, 0, 0, 1, 0, 32'h8000_0000, 32'h0,        1);
        vecs[13] = mk(0, 3'b000, 32'h0000_1234, 0, 4'h0, 0, 0, 0, 1, 32'h8000_0000, 32'h0,        1);
        vecs[14] = mk(0, 3'b000, 32'h0,        0, 4'h0, 1, 0, 0, 0, 32'h8000_0000, 32'h0,        1);
        vecs[15] = mk(0, 3'b000, 32'h0,        0, 4'h0, 0, 0, 0, 0, 32'h8000_0000, 32'h0,        1);
        vecs[16] = mk(0, 3'b010, 32'h0000_0001, 0, 4'h0, 0, 0, 0, 0, 32'h8000_0001, 32'h0,        1);
        vecs[17] = mk(0, 3'b000, 32'hDEAD_BEEF, 0, 4'h0, 0, 0, 0, 1, 32'h8000_0001, 32'hDEAD_BEEF, 1);
        vecs[18] = mk(1, 3'b111, 32'hFFFF_FFFF, 0, 4'h0, 1, 1, 0, 0, 32'h0000_0000, 32'h0,        0);
        vecs[19] = mk(0, 3'b111, 32'hFFFF_FFFF, 1, 4'hF, 1, 1, 0, 0, 32'h0000_03C1, 32'h0,        0);
        vecs[20] = mk(0, 3'b000, 32'h0,        1, 4'hF, 0, 0, 1, 0, 32'h0000_0000, 32'h0,        0);
        vecs[21] = mk(0, 3'b010, 32'h0000_0002, 0, 4'h0, 0, 0, 0, 0, 32'h0000_0002, 32'h0,        0);
        vecs[22] = mk(0, 3'b010, 32'h0000_0003, 0, 4'h0, 0, 0, 0, 1, 32'h0000_0003, 32'h0,        0);
        vecs[23] = mk(0, 3'b010, 32'h0000_0002, 0, 4'h0, 0, 0, 0, 0, 32'h0000_0002, 32'h0000_0003, 0);
        vecs[24] = mk(1, 3'b000, 32'h0,        0, 4'h0, 0, 0, 0, 0, 32'h0000_0000, 32'h0,        0);

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].din, vecs[i].fwe, vecs[i].fl,
                  vecs[i].er, vecs[i].eb, vecs[i].ret, vecs[i].sld);
            check($sformatf("vec%0d dout", i), Dout, vecs[i].exp_dout);
            check($sformatf("vec%0d spsr", i), spsr_out, vecs[i].exp_spsr);
            check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
        end

        // Randomized traffic from the reset state left by the last vector
        m_cpsr = '0;
        for (int i = 0; i < NB; i++) m_spsr[i] = '0;
        m_err = 0;
        for (int n = 0; n < 3000; n++) begin
            bit          r_rst, r_fwe, r_er, r_ret, r_sld;
            logic [2:0]  r_ld;
            logic [31:0] r_din;
            logic [3:0]  r_fl;
            logic [1:0]  r_eb;
            logic [31:0] exp_spsr;
            r_rst = ($urandom_range(0, 99) == 0);
            r_er  = ($urandom_range(0, 7) == 0);
            r_ret = ($urandom_range(0, 6) == 0);
            r_sld = ($urandom_range(0, 5) == 0);
            r_fwe = ($urandom_range(0, 3) == 0);
            r_ld  = 3'($urandom_range(0, 7));
            r_din = $urandom;
            r_fl  = 4'($urandom_range(0, 15));
            r_eb  = 2'($urandom_range(0, 3));
            drive(r_rst, r_ld, r_din, r_fwe, r_fl, r_er, r_eb, r_ret, r_sld);
            model_step(r_rst, r_ld, r_din, r_fwe, r_fl, r_er, r_eb, r_ret, r_sld);
            exp_spsr = ((m_cpsr % NB) != 0) ? m_spsr[m_cpsr % NB] : 32'h0;
            check($sformatf("rnd%0d dout", n), Dout, m_cpsr);
            check($sformatf("rnd%0d spsr", n), spsr_out, exp_spsr);
            check($sformatf("rnd%0d err", n), 32'(err), 32'(m_err));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
